bounce_controller: RTL and testbench

Per-frame motion sequencer for the bouncing-box screensaver. Once per frame, during vertical blanking, it advances the box position and velocity with edge reflection and cycles the box colour on every bounce. One shared reflect/clamp datapath is reused for the x and y axes over successive cycles. It also produces a registered `in_box` flag aligned to the video timer's current pixel position, which the pixel colour path consumes.

---
 rtl/bounce_pkg.sv | 20 ++
 rtl/bounce_reflect.sv | 40 ++++
 rtl/bounce_controller.sv | 135 +++++++++++++
 tb/tb_bounce_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing-box motion sequencer.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COLOR  = 2'd3
  } bounce_state_e;

  localparam logic [2:0] COLOR_RESET = 3'b111;
  localparam logic [2:0] COLOR_FIRST = 3'b001;
  localparam int         VW_DEFAULT  = 4;

  // Colour cycle skips 3'b000 so the box never turns black.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'b111) ? COLOR_FIRST : c + 3'd1;
  endfunction

endpackage

// File: rtl/bounce_reflect.sv
// Combinational per-axis step: advance by velocity, clamp to [0, max] and
// negate the velocity when the trajectory leaves that range.
module bounce_reflect
  import bounce_pkg::*;
#(
  parameter int PW = 10,
  parameter int VW = VW_DEFAULT
) (
  input  logic [PW-1:0] pos,
  input  logic [VW-1:0] vel,
  input  logic [PW-1:0] max,
  output logic [PW-1:0] next_pos,
  output logic [VW-1:0] next_vel,
  output logic          bounce
);

  localparam int W = PW + 2;

  logic signed [W-1:0] traj;
  logic signed [W-1:0] lim;

  assign lim  = $signed({2'b00, max});
  assign traj = $signed({2'b00, pos}) + $signed({{(W-VW){vel[VW-1]}}, vel});

  always_comb begin
    next_pos = traj[PW-1:0];
    next_vel = vel;
    bounce   = 1'b0;
    if (traj[W-1]) begin
      next_pos = '0;
      next_vel = -vel;
      bounce   = 1'b1;
    end else if (traj > lim) begin
      next_pos = max;
      next_vel = -vel;
      bounce   = 1'b1;
    end
  end

endmodule

// File: rtl/bounce_controller.sv
// Per-frame box motion sequencer plus registered in_box flag for the pixel path.
// Optional macro BOUNCE_PAUSE_EN adds a pause input that freezes motion.
module bounce_controller
  import bounce_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BOX_WIDTH     = 100,
  parameter int BOX_HEIGHT    = 100,
  parameter int INIT_X        = 50,
  parameter int INIT_Y        = 50,
  parameter int INIT_XV       = 2,
  parameter int INIT_YV       = 1,
  parameter int VW            = VW_DEFAULT,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
`ifdef BOUNCE_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [XW-1:0] position_x_next,
  input  logic [YW-1:0] position_y_next,
  output logic [XW-1:0] box_x,
  output logic [YW-1:0] box_y,
  output logic [2:0]    color,
  output logic          in_box,
  output logic          busy
);

  localparam int PW = (XW > YW) ? XW : YW;
  localparam logic [PW-1:0] X_MAX = PW'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic [PW-1:0] Y_MAX = PW'(SCREEN_HEIGHT - BOX_HEIGHT);

  bounce_state_e state;
  logic [VW-1:0] xv, yv;
  logic          pending, x_bounce, y_bounce, go;

  logic [PW-1:0] rf_pos, rf_max, rf_next_pos;
  logic [VW-1:0] rf_vel, rf_next_vel;
  logic          rf_bounce;

`ifdef BOUNCE_PAUSE_EN
  assign go = (state == IDLE) && !pause && (frame_tick || pending);
`else
  assign go = (state == IDLE) && (frame_tick || pending);
`endif

  assign busy = (state != IDLE);

  // One shared reflect datapath, steered to the axis being stepped.
  assign rf_pos = (state == STEP_Y) ? PW'(box_y) : PW'(box_x);
  assign rf_vel = (state == STEP_Y) ? yv : xv;
  assign rf_max = (state == STEP_Y) ? Y_MAX : X_MAX;

  bounce_reflect #(.PW(PW), .VW(VW)) u_reflect (
    .pos      (rf_pos),
    .vel      (rf_vel),
    .max      (rf_max),
    .next_pos (rf_next_pos),
    .next_vel (rf_next_vel),
    .bounce   (rf_bounce)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      box_x    <= XW'(INIT_X);
      box_y    <= YW'(INIT_Y);
      xv       <= VW'(INIT_XV);
      yv       <= VW'(INIT_YV);
      color    <= COLOR_RESET;
      x_bounce <= 1'b0;
      y_bounce <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= STEP_X;
            x_bounce <= 1'b0;
            y_bounce <= 1'b0;
          end
        end
        STEP_X: begin
          box_x    <= rf_next_pos[XW-1:0];
          xv       <= rf_next_vel;
          x_bounce <= rf_bounce;
          state    <= STEP_Y;
        end
        STEP_Y: begin
          box_y    <= rf_next_pos[YW-1:0];
          yv       <= rf_next_vel;
          y_bounce <= rf_bounce;
          state    <= COLOR;
        end
        COLOR: begin
          // A corner hit sets both flags but still advances only once.
          if (x_bounce || y_bounce) color <= next_color(color);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // At most one tick is remembered while a sequence is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (go) begin
      pending <= 1'b0;
    end else if (busy && frame_tick) begin
      pending <= 1'b1;
    end
  end

  logic [XW:0] x_end;
  logic [YW:0] y_end;
  logic        in_x, in_y;

  assign x_end = {1'b0, box_x} + (XW+1)'(BOX_WIDTH);
  assign y_end = {1'b0, box_y} + (YW+1)'(BOX_HEIGHT);
  assign in_x  = ({1'b0, position_x_next} >= {1'b0, box_x}) &&
                 ({1'b0, position_x_next} <  x_end);
  assign in_y  = ({1'b0, position_y_next} >= {1'b0, box_y}) &&
                 ({1'b0, position_y_next} <  y_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_box <= 1'b0;
    else     in_box <= in_x && in_y;
  end

endmodule

// File: tb/tb_bounce_controller.sv
// Bench for bounce_controller: three instances (default, right-edge, corner)
// checked against an integer motion model; pause test when BOUNCE_PAUSE_EN is set.
module tb_bounce_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] pos_x_next = '0;
  logic [8:0] pos_y_next = '0;
`ifdef BOUNCE_PAUSE_EN
  logic       pause = 1'b0;
`endif

  logic [9:0] bx [3];
  logic [8:0] by [3];
  logic [2:0] col [3];
  logic       busy [3];
  logic       inb [3];

  int checks = 0;
  int errors = 0;

  int ix [3]  = '{50, 538, 539};
  int iy [3]  = '{50, 50, 379};
  int ixv [3] = '{2, 3, 2};
  int iyv [3] = '{1, 1, 2};
  int mx [3], my [3], mxv [3], myv [3], mc [3];

  always #5 clk = ~clk;

  bounce_controller u0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
`ifdef BOUNCE_PAUSE_EN
    .pause(pause),
`endif
    .position_x_next(pos_x_next), .position_y_next(pos_y_next),
    .box_x(bx[0]), .box_y(by[0]), .color(col[0]), .in_box(inb[0]), .busy(busy[0])
  );

  bounce_controller #(.INIT_X(538), .INIT_XV(3)) u1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
`ifdef BOUNCE_PAUSE_EN
    .pause(pause),
`endif
    .position_x_next(pos_x_next), .position_y_next(pos_y_next),
    .box_x(bx[1]), .box_y(by[1]), .color(col[1]), .in_box(inb[1]), .busy(busy[1])
  );

  bounce_controller #(.INIT_X(539), .INIT_Y(379), .INIT_XV(2), .INIT_YV(2)) u2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
`ifdef BOUNCE_PAUSE_EN
    .pause(pause),
`endif
    .position_x_next(pos_x_next), .position_y_next(pos_y_next),
    .box_x(bx[2]), .box_y(by[2]), .color(col[2]), .in_box(inb[2]), .busy(busy[2])
  );

  // ---------------- reference model ----------------
  function automatic void ref_axis(input int pos, input int vel, input int lim,
                                   output int np, output int nv, output bit b);
    int t;
    t  = pos + vel;
    np = t; nv = vel; b = 1'b0;
    if (t < 0)        begin np = 0;   nv = -vel; b = 1'b1; end
    else if (t > lim) begin np = lim; nv = -vel; b = 1'b1; end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = ix[i]; my[i] = iy[i]; mxv[i] = ixv[i]; myv[i] = iyv[i]; mc[i] = 7;
    end
  endtask

  task automatic model_frame();
    bit b1, b2;
    for (int i = 0; i < 3; i++) begin
      ref_axis(mx[i], mxv[i], 540, mx[i], mxv[i], b1);
      ref_axis(my[i], myv[i], 380, my[i], myv[i], b2);
      if (b1 || b2) mc[i] = mc[i] % 7 + 1;
    end
  endtask

  function automatic bit exp_in_box(input int px, input int py);
    return (px >= mx[0]) && (px < mx[0] + 100) && (py >= my[0]) && (py < my[0] + 100);
  endfunction

  // Stimulus only: one tick pulse, then wait until the sequence has finished.
  task automatic pulse_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bx[i] !== 10'(mx[i]) || by[i] !== 9'(my[i]) || col[i] !== 3'b111 ||
          busy[i] !== 1'b0 || inb[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d] got x=%0d y=%0d c=%0d busy=%0b inb=%0b exp x=%0d y=%0d c=7 busy=0 inb=0",
                 i, bx[i], by[i], col[i], busy[i], inb[i], mx[i], my[i]);
      end
    end
    // Move, then assert reset between edges and look immediately.
    pulse_tick();
    model_frame();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bx[i] !== 10'(mx[i]) || by[i] !== 9'(my[i]) || col[i] !== 3'b111 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset[%0d] got x=%0d y=%0d c=%0d busy=%0b exp x=%0d y=%0d c=7 busy=0",
                 i, bx[i], by[i], col[i], busy[i], mx[i], my[i]);
      end
    end
    @(negedge clk) rst = 1'b0;
    // Reset after the x step but before the sequence completes.
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bx[0] !== 10'd50 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midseq_reset got x=%0d busy=%0b exp x=50 busy=0", bx[0], busy[0]);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_in_box();
    int px [5] = '{149, 150, 50, 49, 149};
    int py [5] = '{149, 149, 50, 50, 150};
    bit ex [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      pos_x_next = 10'(px[k]);
      pos_y_next = 9'(py[k]);
      @(negedge clk);
      checks++;
      if (inb[0] !== ex[k]) begin
        errors++;
        $display("FAIL in_box_edge(%0d,%0d) got %0b exp %0b", px[k], py[k], inb[0], ex[k]);
      end
    end
  endtask

  task automatic test_single_tick();
    int ox [3], oy [3], oc [3];
    int exp_busy [4] = '{1, 1, 1, 0};
    for (int i = 0; i < 3; i++) begin ox[i] = mx[i]; oy[i] = my[i]; oc[i] = mc[i]; end
    model_frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (busy[i] !== 1'(exp_busy[k]) || bx[i] !== 10'(k >= 1 ? mx[i] : ox[i]) ||
            by[i] !== 9'(k >= 2 ? my[i] : oy[i]) || col[i] !== 3'(k >= 3 ? mc[i] : oc[i])) begin
          errors++;
          $display("FAIL tick_timeline[%0d] cyc %0d got busy=%0b x=%0d y=%0d c=%0d exp busy=%0d x=%0d y=%0d c=%0d",
                   i, k, busy[i], bx[i], by[i], col[i], exp_busy[k],
                   k >= 1 ? mx[i] : ox[i], k >= 2 ? my[i] : oy[i], k >= 3 ? mc[i] : oc[i]);
        end
      end
    end
    checks++;
    if (bx[0] !== 10'd52 || by[0] !== 9'd51 || col[0] !== 3'b111) begin
      errors++;
      $display("FAIL first_step got x=%0d y=%0d c=%0d exp x=52 y=51 c=7", bx[0], by[0], col[0]);
    end
    checks++;
    if (bx[1] !== 10'd540 || col[1] !== 3'b001) begin
      errors++;
      $display("FAIL right_edge got x=%0d c=%0d exp x=540 c=1", bx[1], col[1]);
    end
    checks++;
    if (bx[2] !== 10'd540 || by[2] !== 9'd380 || col[2] !== 3'b001) begin
      errors++;
      $display("FAIL corner got x=%0d y=%0d c=%0d exp x=540 y=380 c=1", bx[2], by[2], col[2]);
    end
  endtask

  task automatic test_edges();
    pulse_tick();
    model_frame();
    checks++;
    if (bx[1] !== 10'd537) begin
      errors++;
      $display("FAIL right_edge_return got x=%0d exp x=537", bx[1]);
    end
    checks++;
    if (bx[2] !== 10'd538 || by[2] !== 9'd378 || col[2] !== 3'b001) begin
      errors++;
      $display("FAIL corner_return got x=%0d y=%0d c=%0d exp x=538 y=378 c=1", bx[2], by[2], col[2]);
    end
  endtask

  task automatic test_back_to_back();
    int exp_busy [10] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0};
    @(negedge clk) frame_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) frame_tick = 1'b0;
      checks++;
      if (busy[0] !== 1'(exp_busy[k])) begin
        errors++;
        $display("FAIL back_to_back_busy cyc %0d got %0b exp %0d", k, busy[0], exp_busy[k]);
      end
    end
    model_frame();
    model_frame();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bx[i] !== 10'(mx[i]) || by[i] !== 9'(my[i]) || col[i] !== 3'(mc[i])) begin
        errors++;
        $display("FAIL back_to_back_pos[%0d] got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                 i, bx[i], by[i], col[i], mx[i], my[i], mc[i]);
      end
    end
  endtask

`ifdef BOUNCE_PAUSE_EN
  task automatic test_pause();
    pause = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || bx[i] !== 10'(mx[i]) || by[i] !== 9'(my[i]) || col[i] !== 3'(mc[i])) begin
        errors++;
        $display("FAIL pause_frozen[%0d] got busy=%0b x=%0d y=%0d c=%0d exp busy=0 x=%0d y=%0d c=%0d",
                 i, busy[i], bx[i], by[i], col[i], mx[i], my[i], mc[i]);
      end
    end
    @(negedge clk) pause = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || bx[i] !== 10'(mx[i]) || by[i] !== 9'(my[i])) begin
        errors++;
        $display("FAIL pause_release[%0d] got busy=%0b x=%0d y=%0d exp busy=0 x=%0d y=%0d",
                 i, busy[i], bx[i], by[i], mx[i], my[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int px, py, d, n;
    for (int it = 0; it < 40; it++) begin
      // in_box against the model while the box is stationary
      n = $urandom_range(2, 6);
      px = mx[0] + $urandom_range(0, 6) - 3 + ($urandom_range(0, 1) ? 100 : 0);
      py = my[0] + $urandom_range(0, 6) - 3 + ($urandom_range(0, 1) ? 100 : 0);
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      @(negedge clk);
      pos_x_next = 10'(px); pos_y_next = 9'(py);
      for (int g = 0; g < n; g++) begin
        @(negedge clk);
        checks++;
        if (inb[0] !== exp_in_box(px, py)) begin
          errors++;
          $display("FAIL rand_in_box box(%0d,%0d) pos(%0d,%0d) got %0b exp %0b",
                   mx[0], my[0], px, py, inb[0], exp_in_box(px, py));
        end
        px = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 639) : mx[0] + $urandom_range(0, 104) - 2;
        py = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 479) : my[0] + $urandom_range(0, 104) - 2;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        pos_x_next = 10'(px); pos_y_next = 9'(py);
      end
      // single tick, or a second tick landing while busy
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      model_frame();
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom_range(1, 3);
        repeat (d - 1) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        model_frame();
      end
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bx[i] !== 10'(mx[i]) || by[i] !== 9'(my[i]) || col[i] !== 3'(mc[i]) || busy[i] !== 1'b0) begin
          errors++;
          $display("FAIL rand_frame[%0d] it %0d got x=%0d y=%0d c=%0d busy=%0b exp x=%0d y=%0d c=%0d busy=0",
                   i, it, bx[i], by[i], col[i], busy[i], mx[i], my[i], mc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_box();
    test_single_tick();
    test_edges();
    test_back_to_back();
`ifdef BOUNCE_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
